imem_fetch_arbiter: RTL and testbench

- Shares the single multi-cycle instruction memory between two requesters: the I-cache line refill engine and the debug/loader single-word read port.
- Round-robin arbitration between the two ports.
- Sequences a refill as BURST_LENGTH back-to-back single-word strobe/ack transactions and assembles the returned words into one line.
- Adds a per-beat timeout so a hung memory cannot stall fetch forever.

---
 rtl/imem_fetch_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_imem_fetch_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_arbiter.sv
// imem_fetch_arbiter
// Shares one multi-cycle instruction memory between the I-cache refill engine
// and the debug/loader read port. Round-robin arbitration picks one owner; a
// refill is issued as BURST_LENGTH single-word strobe/ack beats with a one-cycle
// strobe gap between beats, and each beat is bounded by a timeout.
//
// Ports:
//   i_clk, i_rst                     clock, asynchronous active-high reset
//   i_rf_req/i_rf_addr               refill request (line-aligned internally)
//   o_rf_gnt/o_rf_valid/o_rf_line/o_rf_err    refill grant and completion
//   i_dbg_req/i_dbg_addr             debug single-word read request
//   o_dbg_gnt/o_dbg_valid/o_dbg_data/o_dbg_err debug grant and completion
//   o_mem_addr/o_mem_stb, i_mem_ack/i_mem_data memory handshake
//   o_busy                           high whenever not IDLE
module imem_fetch_arbiter #(
    parameter int unsigned ADDR_W       = 13,
    parameter int unsigned BURST_LENGTH = 4,
    parameter int unsigned TIMEOUT      = 64
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_rf_req,
    input  logic [ADDR_W-1:0]         i_rf_addr,
    output logic                      o_rf_gnt,
    output logic                      o_rf_valid,
    output logic [32*BURST_LENGTH-1:0] o_rf_line,
    output logic                      o_rf_err,
    input  logic                      i_dbg_req,
    input  logic [ADDR_W-1:0]         i_dbg_addr,
    output logic                      o_dbg_gnt,
    output logic                      o_dbg_valid,
    output logic [31:0]               o_dbg_data,
    output logic                      o_dbg_err,
    output logic [ADDR_W-1:0]         o_mem_addr,
    output logic                      o_mem_stb,
    input  logic                      i_mem_ack,
    input  logic [31:0]               i_mem_data,
    output logic                      o_busy
);

    localparam int unsigned BEAT_W = $clog2(BURST_LENGTH);
    localparam int unsigned TCNT_W = $clog2(TIMEOUT + 1);
    localparam int unsigned LINE_W = 32 * BURST_LENGTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              state;
    logic                owner_dbg;   // current transaction belongs to the debug port
    logic                prio_dbg;    // debug wins the next contended arbitration
    logic [BEAT_W-1:0]   beat;
    logic [TCNT_W-1:0]   tcnt;
    logic [LINE_W-1:0]   line_buf;

    logic                pick_dbg_c;
    logic                last_beat_c;
    logic [ADDR_W-1:0]   rf_base_c;
    logic [ADDR_W-1:0]   next_addr_c;
    logic [LINE_W-1:0]   line_merged_c;

    // Arbitration, beat addressing and line assembly helpers
    always_comb begin
        pick_dbg_c  = i_dbg_req && (!i_rf_req || prio_dbg);
        last_beat_c = owner_dbg || (beat == BEAT_W'(BURST_LENGTH - 1));
        rf_base_c   = i_rf_addr & ~ADDR_W'(BURST_LENGTH - 1);
        // Only the in-line offset advances, so a line never leaves its aligned block
        next_addr_c = {o_mem_addr[ADDR_W-1:BEAT_W], BEAT_W'(o_mem_addr[BEAT_W-1:0] + 1'b1)};
        line_merged_c = line_buf;
        for (int k = 0; k < BURST_LENGTH; k++) begin
            if (beat == BEAT_W'(k)) begin
                line_merged_c[32*k +: 32] = i_mem_data;
            end
        end
    end

    // Transaction FSM with registered outputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= IDLE;
            owner_dbg   <= 1'b0;
            prio_dbg    <= 1'b0;
            beat        <= '0;
            tcnt        <= '0;
            line_buf    <= '0;
            o_rf_gnt    <= 1'b0;
            o_rf_valid  <= 1'b0;
            o_rf_line   <= '0;
            o_rf_err    <= 1'b0;
            o_dbg_gnt   <= 1'b0;
            o_dbg_valid <= 1'b0;
            o_dbg_data  <= '0;
            o_dbg_err   <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_stb   <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            o_rf_gnt    <= 1'b0;
            o_dbg_gnt   <= 1'b0;
            o_rf_valid  <= 1'b0;
            o_dbg_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_rf_req || i_dbg_req) begin
                        state     <= REQ;
                        o_busy    <= 1'b1;
                        o_mem_stb <= 1'b1;
                        beat      <= '0;
                        tcnt      <= '0;
                        owner_dbg <= pick_dbg_c;
                        prio_dbg  <= !pick_dbg_c;
                        if (pick_dbg_c) begin
                            o_dbg_gnt  <= 1'b1;
                            o_dbg_err  <= 1'b0;
                            o_mem_addr <= i_dbg_addr;
                        end else begin
                            o_rf_gnt   <= 1'b1;
                            o_rf_err   <= 1'b0;
                            o_mem_addr <= rf_base_c;
                        end
                    end
                end
                REQ: begin
                    if (i_mem_ack) begin
                        tcnt      <= '0;
                        o_mem_stb <= 1'b0;
                        if (owner_dbg) begin
                            o_dbg_data <= i_mem_data;
                        end else begin
                            line_buf <= line_merged_c;
                        end
                        if (last_beat_c) begin
                            state <= DONE;
                            if (owner_dbg) begin
                                o_dbg_valid <= 1'b1;
                            end else begin
                                o_rf_valid <= 1'b1;
                                o_rf_line  <= line_merged_c;
                            end
                        end else begin
                            state      <= GAP;
                            beat       <= BEAT_W'(beat + 1'b1);
                            o_mem_addr <= next_addr_c;
                        end
                    end else if (tcnt == TCNT_W'(TIMEOUT - 1)) begin
                        // Beat hung: abort, report error to the owner
                        state     <= DONE;
                        o_mem_stb <= 1'b0;
                        tcnt      <= '0;
                        if (owner_dbg) begin
                            o_dbg_valid <= 1'b1;
                            o_dbg_err   <= 1'b1;
                        end else begin
                            o_rf_valid <= 1'b1;
                            o_rf_err   <= 1'b1;
                        end
                    end else begin
                        tcnt <= TCNT_W'(tcnt + 1'b1);
                    end
                end
                GAP: begin
                    // Single strobe-low cycle so memory sees a fresh strobe
                    state     <= REQ;
                    o_mem_stb <= 1'b1;
                    tcnt      <= '0;
                end
                DONE: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// Directed bench for imem_fetch_arbiter: behavioural memory with programmable
// latency, hang address and stray-ack injection; expected values are hand-derived.
module tb_imem_fetch_arbiter;

    localparam int unsigned ADDR_W = 13;
    localparam int unsigned BL     = 4;
    localparam logic [31:0] BAD    = 32'hBAD0_BAD0;

    logic              clk;
    logic              rst;
    logic              rf_req;
    logic [ADDR_W-1:0] rf_addr;
    logic              dbg_req;
    logic [ADDR_W-1:0] dbg_addr;
    logic              mem_ack;
    logic [31:0]       mem_data;

    logic              o_rf_gnt, o_rf_valid, o_rf_err;
    logic [32*BL-1:0]  o_rf_line;
    logic              o_dbg_gnt, o_dbg_valid, o_dbg_err;
    logic [31:0]       o_dbg_data;
    logic [ADDR_W-1:0] o_mem_addr;
    logic              o_mem_stb, o_busy;

    imem_fetch_arbiter #(.ADDR_W(ADDR_W), .BURST_LENGTH(BL), .TIMEOUT(64)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_rf_req(rf_req), .i_rf_addr(rf_addr),
        .o_rf_gnt(o_rf_gnt), .o_rf_valid(o_rf_valid), .o_rf_line(o_rf_line), .o_rf_err(o_rf_err),
        .i_dbg_req(dbg_req), .i_dbg_addr(dbg_addr),
        .o_dbg_gnt(o_dbg_gnt), .o_dbg_valid(o_dbg_valid), .o_dbg_data(o_dbg_data), .o_dbg_err(o_dbg_err),
        .o_mem_addr(o_mem_addr), .o_mem_stb(o_mem_stb),
        .i_mem_ack(mem_ack), .i_mem_data(mem_data),
        .o_busy(o_busy)
    );

    initial clk = 1'b0;
    initial forever #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Memory model and monitor state
    int                lat = 2;
    int                wcnt = 0;
    bit                hang_en = 0;
    logic [ADDR_W-1:0] hang_addr = '0;
    bit                inj_idle = 0;
    bit                inj_gap = 0;
    int                cyc = 0;
    int                rf_vcnt = 0, dbg_vcnt = 0, both_gnt = 0;
    int                rf_valid_cyc = 0, dbg_gnt_cyc = 0;
    logic [32*BL-1:0]  cap_line = '0;
    logic              cap_rf_err = 0, cap_dbg_err = 0;
    logic [31:0]       cap_dbg = '0;
    logic [ADDR_W-1:0] addr_q[$];
    int                gap_q[$];
    bit                gnt_q[$];
    bit                stb_prev = 0;
    int                low_run = 0, hi_run = 0, last_hi = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mword(input logic [ADDR_W-1:0] a);
        return {16'hC0DE, 3'b000, a};
    endfunction

    // One clock: monitor + memory drive at negedge, requester drops req after grant
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (o_rf_gnt && o_dbg_gnt) both_gnt++;
        if (o_rf_gnt) gnt_q.push_back(1'b0);
        if (o_dbg_gnt) begin gnt_q.push_back(1'b1); dbg_gnt_cyc = cyc; end
        if (o_rf_valid) begin
            rf_vcnt++; cap_line = o_rf_line; cap_rf_err = o_rf_err; rf_valid_cyc = cyc;
        end
        if (o_dbg_valid) begin
            dbg_vcnt++; cap_dbg = o_dbg_data; cap_dbg_err = o_dbg_err;
        end
        if (o_mem_stb && !stb_prev) begin
            addr_q.push_back(o_mem_addr); gap_q.push_back(low_run); low_run = 0; hi_run = 0;
        end
        if (o_mem_stb) hi_run++;
        else begin
            if (stb_prev) last_hi = hi_run;
            low_run++;
        end
        stb_prev = o_mem_stb;
        mem_ack = 1'b0;
        if (inj_idle && !o_busy) begin
            mem_ack = 1'b1; mem_data = BAD; inj_idle = 0;
        end else if (inj_gap && o_busy && !o_mem_stb && !o_rf_valid && !o_dbg_valid) begin
            mem_ack = 1'b1; mem_data = BAD; inj_gap = 0;
        end else if (o_mem_stb && !(hang_en && o_mem_addr == hang_addr)) begin
            wcnt++;
            if (wcnt == lat) begin mem_ack = 1'b1; mem_data = mword(o_mem_addr); wcnt = 0; end
        end else begin
            wcnt = 0;
        end
        @(posedge clk);
        #1;
        if (o_rf_gnt) rf_req = 1'b0;
        if (o_dbg_gnt) dbg_req = 1'b0;
    endtask

    task automatic clr_mon();
        addr_q.delete(); gap_q.delete(); gnt_q.delete();
        rf_vcnt = 0; dbg_vcnt = 0; both_gnt = 0;
    endtask

    task automatic wait_rf(input string tag, input int budget);
        int k = 0;
        while (rf_vcnt == 0 && k < budget) begin tick(); k++; end
        check(tag, 128'(k < budget), 128'(1));
    endtask

    task automatic wait_dbg(input string tag, input int budget);
        int k = 0;
        while (dbg_vcnt == 0 && k < budget) begin tick(); k++; end
        check(tag, 128'(k < budget), 128'(1));
    endtask

    task automatic wait_both(input string tag, input int budget);
        int k = 0;
        while (!(rf_vcnt > 0 && dbg_vcnt > 0) && k < budget) begin tick(); k++; end
        check(tag, 128'(k < budget), 128'(1));
    endtask

    initial begin
        rst = 1'b1; rf_req = 0; dbg_req = 0; rf_addr = '0; dbg_addr = '0;
        mem_ack = 0; mem_data = '0;
        repeat (3) tick();
        check("rst_stb",   128'(o_mem_stb), 128'(0));
        check("rst_busy",  128'(o_busy), 128'(0));
        check("rst_gnt",   128'({o_rf_gnt, o_dbg_gnt}), 128'(0));
        check("rst_valid", 128'({o_rf_valid, o_dbg_valid}), 128'(0));
        check("rst_err",   128'({o_rf_err, o_dbg_err}), 128'(0));
        check("rst_line",  128'(o_rf_line), 128'(0));
        check("rst_dbgd",  128'(o_dbg_data), 128'(0));
        check("rst_addr",  128'(o_mem_addr), 128'(0));
        rst = 1'b0;
        tick();

        // Simultaneous requests after reset: refill wins, debug follows after DONE+IDLE
        clr_mon(); lat = 2;
        rf_addr = 13'h040; dbg_addr = 13'h123; rf_req = 1; dbg_req = 1;
        wait_both("p1_done", 400);
        check("p1_ngnt", 128'(gnt_q.size()), 128'(2));
        check("p1_first_rf", 128'(gnt_q[0]), 128'(0));
        check("p1_second_dbg", 128'(gnt_q[1]), 128'(1));
        check("p1_dbg_gnt_delay", 128'(dbg_gnt_cyc - rf_valid_cyc), 128'(2));
        check("p1_line", cap_line, 128'hC0DE0043_C0DE0042_C0DE0041_C0DE0040);
        check("p1_dbg", 128'(cap_dbg), 128'(32'hC0DE0123));
        check("p1_both_gnt", 128'(both_gnt), 128'(0));

        // Refill at 0x105, latency 11
        clr_mon(); lat = 11; rf_addr = 13'h105; rf_req = 1;
        wait_rf("rf105_done", 400);
        repeat (3) tick();
        check("rf105_nbeats", 128'(addr_q.size()), 128'(4));
        for (int i = 0; i < 4; i++) check($sformatf("rf105_addr%0d", i), 128'(addr_q[i]), 128'(13'h104 + i));
        for (int i = 1; i < 4; i++) check($sformatf("rf105_gap%0d", i), 128'(gap_q[i]), 128'(1));
        check("rf105_stb_hi", 128'(last_hi), 128'(11));
        check("rf105_nvalid", 128'(rf_vcnt), 128'(1));
        check("rf105_no_dbg", 128'(dbg_vcnt), 128'(0));
        check("rf105_line", cap_line, 128'hC0DE0107_C0DE0106_C0DE0105_C0DE0104);
        check("rf105_err", 128'(cap_rf_err), 128'(0));

        // Second simultaneous pair: last grant was refill, so debug goes first
        clr_mon(); lat = 2;
        rf_addr = 13'h080; dbg_addr = 13'h0AA; rf_req = 1; dbg_req = 1;
        wait_both("p2_done", 400);
        check("p2_ngnt", 128'(gnt_q.size()), 128'(2));
        check("p2_first_dbg", 128'(gnt_q[0]), 128'(1));
        check("p2_second_rf", 128'(gnt_q[1]), 128'(0));
        check("p2_line", cap_line, 128'hC0DE0083_C0DE0082_C0DE0081_C0DE0080);
        check("p2_dbg", 128'(cap_dbg), 128'(32'hC0DE00AA));

        // Debug read at the top word
        clr_mon(); lat = 3; dbg_addr = 13'h1FFF; dbg_req = 1;
        wait_dbg("dbg1fff_done", 200);
        repeat (3) tick();
        check("dbg1fff_nbeats", 128'(addr_q.size()), 128'(1));
        check("dbg1fff_addr", 128'(addr_q[0]), 128'(13'h1FFF));
        check("dbg1fff_stb_hi", 128'(last_hi), 128'(3));
        check("dbg1fff_data", 128'(cap_dbg), 128'(32'hC0DE1FFF));
        check("dbg1fff_nvalid", 128'(dbg_vcnt), 128'(1));
        check("dbg1fff_no_rf", 128'(rf_vcnt), 128'(0));
        check("dbg1fff_err", 128'(cap_dbg_err), 128'(0));

        // Timeout on beat 2, late ack afterwards, then a clean refill clears err
        clr_mon(); lat = 2; hang_en = 1; hang_addr = 13'h202; rf_addr = 13'h201; rf_req = 1;
        wait_rf("to_done", 400);
        tick();
        inj_idle = 1;
        repeat (4) tick();
        check("to_err", 128'(cap_rf_err), 128'(1));
        check("to_stb_hi", 128'(last_hi), 128'(64));
        check("to_nbeats", 128'(addr_q.size()), 128'(3));
        check("to_hang_addr", 128'(addr_q[2]), 128'(13'h202));
        check("to_nvalid", 128'(rf_vcnt), 128'(1));
        check("to_idle_busy", 128'(o_busy), 128'(0));
        check("to_err_held", 128'(o_rf_err), 128'(1));
        hang_en = 0;
        clr_mon(); rf_addr = 13'h300; rf_req = 1;
        wait_rf("rec_done", 400);
        check("rec_err", 128'(cap_rf_err), 128'(0));
        check("rec_line", cap_line, 128'hC0DE0303_C0DE0302_C0DE0301_C0DE0300);

        // Reset during beat 2 of a refill
        clr_mon(); lat = 5; rf_addr = 13'h0A0; rf_req = 1;
        for (int k = 0; k < 200 && addr_q.size() < 3; k++) tick();
        check("rst_mid_reached", 128'(addr_q.size()), 128'(3));
        rst = 1'b1;
        #1;
        check("rst_mid_stb", 128'(o_mem_stb), 128'(0));
        check("rst_mid_busy", 128'(o_busy), 128'(0));
        check("rst_mid_valid", 128'({o_rf_valid, o_dbg_valid}), 128'(0));
        repeat (2) tick();
        rst = 1'b0;
        repeat (5) tick();
        check("rst_mid_no_valid", 128'(rf_vcnt + dbg_vcnt), 128'(0));
        clr_mon(); lat = 2; dbg_addr = 13'h0A5; dbg_req = 1;
        wait_dbg("post_rst_done", 200);
        check("post_rst_data", 128'(cap_dbg), 128'(32'hC0DE00A5));
        check("post_rst_err", 128'(cap_dbg_err), 128'(0));

        // Stray acks while IDLE and in a GAP cycle are ignored; line at the top boundary
        clr_mon(); inj_idle = 1;
        repeat (3) tick();
        check("idle_ack_dbgd", 128'(o_dbg_data), 128'(32'hC0DE00A5));
        check("idle_ack_busy", 128'(o_busy), 128'(0));
        lat = 4; inj_gap = 1; rf_addr = 13'h1FFE; rf_req = 1;
        wait_rf("gap_done", 400);
        check("gap_injected", 128'(inj_gap), 128'(0));
        check("gap_nbeats", 128'(addr_q.size()), 128'(4));
        for (int i = 0; i < 4; i++) check($sformatf("gap_addr%0d", i), 128'(addr_q[i]), 128'(13'h1FFC + i));
        check("gap_line", cap_line, 128'hC0DE1FFF_C0DE1FFE_C0DE1FFD_C0DE1FFC);
        check("gap_err", 128'(cap_rf_err), 128'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
